// File: rtl/kersram_pkg.sv
// Shared constants and FSM encoding for the kernel SRAM reader.
// No logic; imported by the interface, the FIFO and the top.
// Backpressure: not applicable.
package kersram_pkg;

  localparam int NUM_KSRAM         = 8;
  localparam int DEF_DATA_W        = 64;
  localparam int DEF_ADDR_CNT_BITS = 10;
  localparam int SKID_DEPTH        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ker_state_t;

endpackage

// File: rtl/kersram_if.sv
// Control/config and output-stream bundle of the kernel SRAM reader.
// No logic; slave modport is the reader, master is its user.
// Backpressure: ker_read_ready_din stalls the output stream.
interface kersram_if #(
  parameter int ADDR_CNT_BITS = kersram_pkg::DEF_ADDR_CNT_BITS,
  parameter int DATA_W        = kersram_pkg::DEF_DATA_W
);

  logic                                   start_ker_read;
  logic [ADDR_CNT_BITS-1:0]               cfg_kerr_buflength;
  logic [7:0]                             cfg_kerr_repeat;
  logic [kersram_pkg::NUM_KSRAM*DATA_W-1:0] ker_read_data_dout;
  logic                                   ker_read_valid_dout;
  logic                                   ker_read_ready_din;
  logic                                   ker_read_last_dout;
  logic                                   ker_read_busy;
  logic                                   ker_read_done;

  modport master (
    output start_ker_read, cfg_kerr_buflength, cfg_kerr_repeat, ker_read_ready_din,
    input  ker_read_data_dout, ker_read_valid_dout, ker_read_last_dout,
           ker_read_busy, ker_read_done
  );

  modport slave (
    input  start_ker_read, cfg_kerr_buflength, cfg_kerr_repeat, ker_read_ready_din,
    output ker_read_data_dout, ker_read_valid_dout, ker_read_last_dout,
           ker_read_busy, ker_read_done
  );

endinterface

// File: rtl/ker_skid_fifo.sv
// Two-entry FIFO holding captured SRAM words plus their last flag.
// Latency: a push is visible at the head the following cycle.
// Backpressure: pushes while full and pops while empty are dropped.
module ker_skid_fifo #(
  parameter int WIDTH = kersram_pkg::NUM_KSRAM * kersram_pkg::DEF_DATA_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared on reset so the output bus reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/kersram_r.sv
// Streams buflength words x repeat passes from 8 lockstep kernel SRAMs.
// Latency: first word valid 2 cycles after the first read issue, then 1/cycle.
// Backpressure: reads issue only while FIFO words + in-flight reads stay below 2.
module kersram_r
  import kersram_pkg::*;
#(
  parameter int ADDR_CNT_BITS = DEF_ADDR_CNT_BITS,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  kersram_if.slave                 kif,
  output logic                     cen_kersr_0,
  output logic                     cen_kersr_1,
  output logic                     cen_kersr_2,
  output logic                     cen_kersr_3,
  output logic                     cen_kersr_4,
  output logic                     cen_kersr_5,
  output logic                     cen_kersr_6,
  output logic                     cen_kersr_7,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_0,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_1,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_2,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_3,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_4,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_5,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_6,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_7,
  input  logic [DATA_W-1:0]        dout_kersr_0,
  input  logic [DATA_W-1:0]        dout_kersr_1,
  input  logic [DATA_W-1:0]        dout_kersr_2,
  input  logic [DATA_W-1:0]        dout_kersr_3,
  input  logic [DATA_W-1:0]        dout_kersr_4,
  input  logic [DATA_W-1:0]        dout_kersr_5,
  input  logic [DATA_W-1:0]        dout_kersr_6,
  input  logic [DATA_W-1:0]        dout_kersr_7
);

  localparam int WORD_W = NUM_KSRAM * DATA_W;
  localparam int FIFO_W = WORD_W + 1;

  ker_state_t               state;
  ker_state_t               state_nxt;
  logic [ADDR_CNT_BITS-1:0] len_q;
  logic [7:0]               rep_q;
  logic [ADDR_CNT_BITS-1:0] addr_cnt;
  logic [7:0]               pass_cnt;
  logic                     cap_vld;
  logic                     cap_last;

  logic                     start_acc;
  logic                     issue;
  logic                     addr_at_end;
  logic                     pass_at_end;
  logic                     final_rd;
  logic                     pop;
  logic [2:0]               credit;
  logic [ADDR_CNT_BITS-1:0] rd_addr;

  logic [FIFO_W-1:0]        fifo_wr;
  logic [FIFO_W-1:0]        fifo_rd;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               fifo_cnt;

  assign start_acc   = (state == ST_IDLE) && kif.start_ker_read;
  assign pop         = !fifo_empty && kif.ker_read_ready_din;
  // Counting this cycle's pop lets a read issue every cycle under full throughput.
  assign credit      = 3'(fifo_cnt) + 3'(cap_vld) - 3'(pop);
  assign issue       = (state == ST_RUN) && (len_q != '0) && (credit < 3'd2);
  assign addr_at_end = (addr_cnt == len_q - ADDR_CNT_BITS'(1));
  assign pass_at_end = (pass_cnt == rep_q - 8'd1);
  assign final_rd    = issue && addr_at_end && pass_at_end;
  assign rd_addr     = issue ? addr_cnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (kif.start_ker_read) state_nxt = ST_RUN;
      ST_RUN: begin
        if (len_q == '0)   state_nxt = ST_DONE;
        else if (final_rd) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty && !cap_vld) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      rep_q    <= 8'd0;
      addr_cnt <= '0;
      pass_cnt <= 8'd0;
      cap_vld  <= 1'b0;
      cap_last <= 1'b0;
    end else begin
      cap_vld  <= issue;
      cap_last <= issue && addr_at_end;
      if (start_acc) begin
        len_q    <= kif.cfg_kerr_buflength;
        rep_q    <= (kif.cfg_kerr_repeat == 8'd0) ? 8'd1 : kif.cfg_kerr_repeat;
        addr_cnt <= '0;
        pass_cnt <= 8'd0;
      end else if (issue) begin
        if (addr_at_end) begin
          addr_cnt <= '0;
          pass_cnt <= pass_cnt + 8'd1;
        end else begin
          addr_cnt <= addr_cnt + ADDR_CNT_BITS'(1);
        end
      end
    end
  end

  assign fifo_wr = {cap_last, dout_kersr_7, dout_kersr_6, dout_kersr_5, dout_kersr_4,
                    dout_kersr_3, dout_kersr_2, dout_kersr_1, dout_kersr_0};

  ker_skid_fifo #(.WIDTH(FIFO_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cap_vld),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // The credit check above must make an overflowing push impossible.
  assert property (@(posedge clk) disable iff (reset) !(fifo_full && cap_vld && !pop));

  assign kif.ker_read_valid_dout = !fifo_empty;
  assign kif.ker_read_data_dout  = fifo_rd[WORD_W-1:0];
  assign kif.ker_read_last_dout  = fifo_rd[FIFO_W-1];
  assign kif.ker_read_busy       = (state != ST_IDLE);
  assign kif.ker_read_done       = (state == ST_DONE);

  assign cen_kersr_0 = !issue;
  assign cen_kersr_1 = !issue;
  assign cen_kersr_2 = !issue;
  assign cen_kersr_3 = !issue;
  assign cen_kersr_4 = !issue;
  assign cen_kersr_5 = !issue;
  assign cen_kersr_6 = !issue;
  assign cen_kersr_7 = !issue;

  assign addr_kersr_0 = rd_addr;
  assign addr_kersr_1 = rd_addr;
  assign addr_kersr_2 = rd_addr;
  assign addr_kersr_3 = rd_addr;
  assign addr_kersr_4 = rd_addr;
  assign addr_kersr_5 = rd_addr;
  assign addr_kersr_6 = rd_addr;
  assign addr_kersr_7 = rd_addr;

endmodule

// File: tb/tb_kersram_r.sv
// Scoreboard bench for kersram_r: directed runs, a monitor checks every presented word.
module tb_kersram_r;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int WW = 8 * DW;

  logic clk;
  logic reset;
  logic          cen  [8];
  logic [AW-1:0] addr [8];
  logic [DW-1:0] dout [8];

  kersram_if #(.ADDR_CNT_BITS(AW), .DATA_W(DW)) kif ();

  kersram_r #(.ADDR_CNT_BITS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .kif(kif),
    .cen_kersr_0(cen[0]), .cen_kersr_1(cen[1]), .cen_kersr_2(cen[2]), .cen_kersr_3(cen[3]),
    .cen_kersr_4(cen[4]), .cen_kersr_5(cen[5]), .cen_kersr_6(cen[6]), .cen_kersr_7(cen[7]),
    .addr_kersr_0(addr[0]), .addr_kersr_1(addr[1]), .addr_kersr_2(addr[2]), .addr_kersr_3(addr[3]),
    .addr_kersr_4(addr[4]), .addr_kersr_5(addr[5]), .addr_kersr_6(addr[6]), .addr_kersr_7(addr[7]),
    .dout_kersr_0(dout[0]), .dout_kersr_1(dout[1]), .dout_kersr_2(dout[2]), .dout_kersr_3(dout[3]),
    .dout_kersr_4(dout[4]), .dout_kersr_5(dout[5]), .dout_kersr_6(dout[6]), .dout_kersr_7(dout[7])
  );

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  int cen_low, issued, popped, done_cnt, done_cyc, first_vld, last_vld, st_cyc;
  logic [WW:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM n returns {n, addr} one cycle after a read.
  always @(posedge clk) begin
    for (int n = 0; n < 8; n++) begin
      if (!cen[n]) dout[n] <= (64'(n) << 32) | 64'(addr[n]);
    end
  end

  // Ready: 0 = held high, 1 = pattern 1,0,0,1, 2 = held low.
  initial begin
    kif.ker_read_ready_din = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       kif.ker_read_ready_din = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       kif.ker_read_ready_din = 1'b0;
        default: kif.ker_read_ready_din = 1'b1;
      endcase
    end
  end

  function automatic logic [WW:0] exp_word(int a, bit lst);
    logic [WW:0] w;
    w = '0;
    for (int n = 0; n < 8; n++) w[n*DW +: DW] = (64'(n) << 32) | 64'(a);
    w[WW] = lst;
    return w;
  endfunction

  task automatic chk32(string nm, int act, int expv);
    chk++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  task automatic chkw(string nm, logic [WW:0] act, logic [WW:0] expv);
    chk++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic monitor();
    bit ok;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ok = 1'b1;
        for (int n = 1; n < 8; n++) begin
          if (cen[n] !== cen[0] || addr[n] !== addr[0]) ok = 1'b0;
        end
        if (cen[0] === 1'b1 && addr[0] !== '0) ok = 1'b0;
        chk32("lockstep", int'(ok), 1);
        if (cen[0] === 1'b0) begin
          cen_low++;
          issued++;
        end
        if (kif.ker_read_valid_dout) begin
          if (exp_q.size() == 0) begin
            chk++;
            err++;
            $display("FAIL unexpected_word actual=%h expected=none",
                     {kif.ker_read_last_dout, kif.ker_read_data_dout});
          end else begin
            chkw("word", {kif.ker_read_last_dout, kif.ker_read_data_dout}, exp_q[0]);
            if (kif.ker_read_ready_din) begin
              void'(exp_q.pop_front());
              popped++;
              if (first_vld < 0) first_vld = cyc;
              last_vld = cyc;
            end
          end
        end
        chk32("outstanding_le2", int'((issued - popped) <= 2), 1);
        if (kif.ker_read_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic clear_stats();
    cen_low = 0; issued = 0; popped = 0; done_cnt = 0;
    done_cyc = -1; first_vld = -1; last_vld = -1;
  endtask

  task automatic run_test(int len, int rep, int mode, bit bump, bit poke);
    int reps;
    int t;
    clear_stats();
    rdy_mode = mode;
    reps = (rep == 0) ? 1 : rep;
    for (int p = 0; p < reps; p++)
      for (int a = 0; a < len; a++) exp_q.push_back(exp_word(a, a == len - 1));
    @(posedge clk);
    #1;
    kif.start_ker_read     = 1'b1;
    kif.cfg_kerr_buflength = AW'(len);
    kif.cfg_kerr_repeat    = 8'(rep);
    st_cyc = cyc;
    @(negedge clk);
    chk32("busy_in_start_cycle", int'(kif.ker_read_busy), 0);
    @(posedge clk);
    #1;
    kif.start_ker_read = 1'b0;
    @(negedge clk);
    chk32("busy_after_start", int'(kif.ker_read_busy), 1);
    if (bump) begin
      @(posedge clk);
      #1;
      kif.start_ker_read     = 1'b1;
      kif.cfg_kerr_buflength = AW'(9);
      kif.cfg_kerr_repeat    = 8'd3;
      @(posedge clk);
      #1;
      kif.start_ker_read = 1'b0;
    end
    t = 0;
    while (!kif.ker_read_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk32("done_seen", int'(kif.ker_read_done), 1);
    if (poke) kif.start_ker_read = 1'b1;
    @(posedge clk);
    #1;
    kif.start_ker_read = 1'b0;
    @(negedge clk);
    chk32("busy_after_done", int'(kif.ker_read_busy), 0);
    chk32("done_one_cycle", int'(kif.ker_read_done), 0);
    repeat (3) @(negedge clk);
    chk32("cen_low_cycles", cen_low, len * reps);
    chk32("words_popped", popped, len * reps);
    chk32("queue_drained", exp_q.size(), 0);
    chk32("done_pulses", done_cnt, 1);
    chk32("busy_idle", int'(kif.ker_read_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    kif.start_ker_read     = 1'b0;
    kif.cfg_kerr_buflength = '0;
    kif.cfg_kerr_repeat    = 8'd0;
    clear_stats();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk32("rst_cen", int'(cen[0]), 1);
    chk32("rst_addr", int'(addr[0]), 0);
    chk32("rst_valid", int'(kif.ker_read_valid_dout), 0);
    chk32("rst_busy", int'(kif.ker_read_busy), 0);
    chk32("rst_done", int'(kif.ker_read_done), 0);
    chkw("rst_data", {kif.ker_read_last_dout, kif.ker_read_data_dout}, '0);
    reset = 1'b0;

    run_test(4, 1, 0, 1'b0, 1'b0);
    chk32("t1_first_latency", first_vld - st_cyc, 3);
    chk32("t1_last_word_cyc", last_vld - st_cyc, 6);
    chk32("t1_done_cyc", done_cyc - st_cyc, 8);

    run_test(2, 0, 0, 1'b0, 1'b0);
    run_test(3, 2, 0, 1'b0, 1'b0);
    run_test(8, 1, 1, 1'b0, 1'b0);

    run_test(0, 1, 0, 1'b0, 1'b0);
    chk32("t4_done_cyc", done_cyc - st_cyc, 2);
    chk32("t4_no_valid", first_vld, -1);

    // Reset mid-run once address 5 has been read, with the sink stalled.
    clear_stats();
    rdy_mode = 0;
    for (int a = 0; a < 10; a++) exp_q.push_back(exp_word(a, a == 9));
    @(posedge clk);
    #1;
    kif.start_ker_read     = 1'b1;
    kif.cfg_kerr_buflength = AW'(10);
    kif.cfg_kerr_repeat    = 8'd1;
    @(posedge clk);
    #1;
    kif.start_ker_read = 1'b0;
    t = 0;
    while (!(cen[0] === 1'b0 && addr[0] == AW'(5)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk32("reached_addr5", int'(addr[0]), 5);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk32("mid_rst_cen", int'(cen[0] & cen[7]), 1);
    chk32("mid_rst_addr", int'(addr[0] | addr[7]), 0);
    chk32("mid_rst_valid", int'(kif.ker_read_valid_dout), 0);
    chk32("mid_rst_last", int'(kif.ker_read_last_dout), 0);
    chk32("mid_rst_busy", int'(kif.ker_read_busy), 0);
    chk32("mid_rst_done", int'(kif.ker_read_done), 0);
    chkw("mid_rst_data", {kif.ker_read_last_dout, kif.ker_read_data_dout}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk32("mid_rst_no_done", done_cnt, 0);
    run_test(2, 1, 0, 1'b0, 1'b0);

    run_test(5, 1, 0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/kersram_r.md
KERSRAM_R -- requirements
Module: kersram_r

Interface
REQ-001 Parameter ADDR_CNT_BITS, default 10: address width of each kernel SRAM.
REQ-002 Parameter DATA_W, default 64: word width of each kernel SRAM.
REQ-003 clk  input  1: single clock; all state on rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 start_ker_read  input  1: one-cycle start pulse; ignored while busy.
REQ-006 cfg_kerr_buflength  input  ADDR_CNT_BITS: words per SRAM per pass; addresses 0..cfg_kerr_buflength-1.
REQ-007 cfg_kerr_repeat  input  8: pass count; 0 is treated as 1.
REQ-008 cen_kersr_0..7  output  1 each: SRAM chip enable, active-low.
REQ-009 addr_kersr_0..7  output  ADDR_CNT_BITS each: SRAM read address.
REQ-010 dout_kersr_0..7  input  DATA_W each: SRAM read data, valid exactly 1 cycle after the read.
REQ-011 ker_read_data_dout  output  8*DATA_W: {dout_kersr_7..dout_kersr_0}, with SRAM 0 in the LSBs.
REQ-012 ker_read_valid_dout  output  1: output word valid.
REQ-013 ker_read_ready_din  input  1: downstream PE array accepts the word.
REQ-014 ker_read_last_dout  output  1: word is the final address of a pass.
REQ-015 ker_read_busy  output  1: high from the cycle after start until done, inclusive.
REQ-016 ker_read_done  output  1: one-cycle pulse at completion.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start_ker_read.
- RUN->DRAIN when the final read (last address of the last pass) issues.
- DRAIN->DONE when the buffer is empty and no read is in flight.
- DONE->IDLE unconditionally.
REQ-018 cfg_kerr_buflength and cfg_kerr_repeat are latched on start; later changes have no effect until the next start.
REQ-019 If the latched buflength is 0: RUN->DONE directly, no reads issued, no output words.
REQ-020 All 8 SRAMs are read in lockstep.
- cen_kersr_0..7 are low together only in a read-issue cycle.
- All addr_kersr_n carry the same address counter value.
- Outside a read-issue cycle, addresses are 0.
REQ-021 A read issues in RUN only when (buffer occupancy + reads in flight) < 2, so backpressure never loses data.
REQ-022 Address counter behaviour per issued read:
- increments 0..buflength-1;
- at buflength-1 wraps to 0 and increments the pass counter;
- the final read is address buflength-1 on pass repeat-1.
REQ-023 The data capture flag is the issue flag delayed 1 cycle; the capture pushes the concatenated dout plus its last flag into a 2-entry FIFO.
REQ-024 Output handshake:
- ker_read_valid_dout = FIFO not empty.
- A word pops when valid & ready.
- With ready held high, throughput is 1 word/cycle after a latency of 2 cycles from the first issue.
REQ-025 Output data and last flag are held stable while valid & !ready.
REQ-026 Simultaneous push and pop on a full FIFO is not possible (guaranteed by REQ-021); simultaneous push and pop at occupancy 1 keeps occupancy at 1.
REQ-027 ker_read_busy is high in RUN, DRAIN and DONE; ker_read_done is high only in DONE.
REQ-028 A start pulse arriving in DONE or while busy is ignored.

Reset
REQ-029 Reset values:
- FSM = IDLE; counters = 0; FIFO empty; in-flight flag = 0.
- cen_kersr_n = 1; addr_kersr_n = 0.
- valid, last, busy and done = 0.
- ker_read_data_dout = 0.
REQ-030 Reset mid-operation aborts immediately: no further SRAM reads, pending words are discarded, and no done pulse is produced.

Structure
REQ-031 Package kersram_pkg holds: FSM state encodings, NUM_KSRAM = 8, default DATA_W = 64, default ADDR_CNT_BITS = 10.
REQ-032 Sub-module ker_skid_fifo: 2-entry, width 8*DATA_W+1, with push, pop, full, empty and count outputs.
REQ-033 The remaining logic (FSM, address/pass counters, issue/credit logic) lives in kersram_r.

Verification
REQ-034 buflength=4, repeat=1, ready=1, SRAM n returns {n, addr}:
- expect 4 words, addresses 0..3 in order;
- last asserted on the 4th word only;
- done one cycle after the DONE transition; busy deasserts the next cycle.
REQ-035 buflength=3, repeat=2: 6 words with addresses 0,1,2,0,1,2; last asserted on words 3 and 6; exactly 6 cen-low cycles.
REQ-036 buflength=8, ready toggling 1,0,0,1 repeatedly:
- no lost or duplicated word;
- data stable while stalled;
- reads stall within 1 cycle of the FIFO filling to 2.
REQ-037 buflength=0: no cen low, no valid; done pulses 2 cycles after start.
REQ-038 Reset asserted mid-RUN at address 5 of 10, with ready=0:
- all outputs at reset values within the same cycle;
- after deassert and a new start (buflength=2), exactly 2 fresh words appear.
REQ-039 Start repulsed during RUN, and cfg changed during RUN: no effect on sequence length or address pattern.
